// File: rtl/fractal_sync_rf_sched.sv
// fractal_sync_rf_sched
// Request scheduler in front of one fractal_sync local RF (or one H/V half of
// the 2D RF). N_REQ requesters hand in barrier-check requests over valid/ready.
// Up to N_PORTS pending requests per cycle are granted round-robin onto the
// RF check ports. The RF verdict is latched and returned to each requester on
// its own response handshake.

module fractal_sync_rf_sched #(
    parameter int N_REQ    = 4,
    parameter int N_PORTS  = 2,
    parameter int ID_WIDTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_REQ-1:0]                  req_valid_i,
    input  logic [N_REQ-1:0][ID_WIDTH-1:0]    req_id_i,
    output logic [N_REQ-1:0]                  req_ready_o,
    output logic [N_REQ-1:0]                  rsp_valid_o,
    output logic [N_REQ-1:0][2:0]             rsp_code_o,
    input  logic [N_REQ-1:0]                  rsp_ready_i,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]  rf_id_o,
    output logic [N_PORTS-1:0]                rf_check_o,
    input  logic [N_PORTS-1:0]                rf_present_i,
    input  logic [N_PORTS-1:0]                rf_id_err_i,
    input  logic [N_PORTS-1:0]                rf_bypass_i,
    input  logic [N_PORTS-1:0]                rf_ignore_i
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [2:0] CODE_RECORDED = 3'd0;
    localparam logic [2:0] CODE_MATCHED  = 3'd1;
    localparam logic [2:0] CODE_BYPASS   = 3'd2;
    localparam logic [2:0] CODE_IGNORED  = 3'd3;
    localparam logic [2:0] CODE_ID_ERR   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // Parameter sanity: the arbiter assumes at least one port and never more
    // ports than requesters.
    if (N_PORTS < 1) begin : g_bad_ports
        $fatal(1, "fractal_sync_rf_sched: N_PORTS must be >= 1");
    end
    if (N_REQ < N_PORTS) begin : g_bad_req
        $fatal(1, "fractal_sync_rf_sched: N_REQ must be >= N_PORTS");
    end

    state_t                r_state     [N_REQ];
    state_t                w_state_nxt [N_REQ];
    logic [ID_WIDTH-1:0]   r_id        [N_REQ];
    logic [2:0]            r_code      [N_REQ];
    logic [PTR_W-1:0]      r_rr_ptr;

    logic [N_REQ-1:0]      w_grant;
    logic [PORT_W-1:0]     w_grant_port [N_REQ];
    logic                  w_any_grant;
    logic [PTR_W-1:0]      w_rr_nxt;
    logic [2:0]            w_verdict    [N_PORTS];

    // Round-robin arbiter: scan from r_rr_ptr and hand PEND requesters to
    // ports 0,1,... in scan order; each requester is visited once, so it can
    // never land on two ports.
    always_comb begin
        logic [PTR_W-1:0]  idx;
        logic [PTR_W-1:0]  last_idx;
        logic [PORT_W-1:0] port_sel;
        int                used;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        idx         = '0;
        last_idx    = r_rr_ptr;
        port_sel    = '0;
        used        = 0;
        w_grant     = '0;
        w_any_grant = 1'b0;
        rf_check_o  = '0;
        rf_id_o     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_grant_port[i] = '0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (r_state[idx] == S_PEND && used < N_PORTS) begin
                port_sel              = PORT_W'(used);
                w_grant[idx]          = 1'b1;
                w_grant_port[idx]     = port_sel;
                rf_check_o[port_sel]  = 1'b1;
                rf_id_o[port_sel]     = r_id[idx];
                last_idx              = idx;
                w_any_grant           = 1'b1;
                used                  = used + 1;
            end
        end
        w_rr_nxt = PTR_W'((int'(last_idx) + 1) % N_REQ);
    end

    // Verdict decode per port, highest priority first.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (rf_id_err_i[p]) begin
                w_verdict[p] = CODE_ID_ERR;
            end else if (rf_ignore_i[p]) begin
                w_verdict[p] = CODE_IGNORED;
            end else if (rf_bypass_i[p]) begin
                w_verdict[p] = CODE_BYPASS;
            end else if (rf_present_i[p]) begin
                w_verdict[p] = CODE_MATCHED;
            end else begin
                w_verdict[p] = CODE_RECORDED;
            end
        end
    end

    // Per-requester next state: IDLE accepts, PEND waits for a grant, RSP
    // waits for the response handshake.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE:  if (req_valid_i[i]) w_state_nxt[i] = S_PEND;
                S_PEND:  if (w_grant[i])     w_state_nxt[i] = S_RSP;
                S_RSP:   if (rsp_ready_i[i]) w_state_nxt[i] = S_IDLE;
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; the code is only shown while
    // a response is being offered.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = (r_state[i] == S_IDLE);
            rsp_valid_o[i] = (r_state[i] == S_RSP);
            rsp_code_o[i]  = (r_state[i] == S_RSP) ? r_code[i] : 3'd0;
        end
    end

    // State, stored id/code and round-robin pointer; reset discards any
    // pending request or unconsumed response.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            r_rr_ptr <= '0;
            // NOTE: the id/code arrays are tiny per-requester registers, not a
            // RAM, so clearing them in reset is cheap and keeps outputs defined.
            for (int i = 0; i < N_REQ; i++) begin
                r_state[i] <= S_IDLE;
                r_id[i]    <= '0;
                r_code[i]  <= '0;
            end
        end else begin
            if (w_any_grant) begin
                r_rr_ptr <= w_rr_nxt;
            end
            for (int i = 0; i < N_REQ; i++) begin
                r_state[i] <= w_state_nxt[i];
                if (r_state[i] == S_IDLE && req_valid_i[i]) begin
                    r_id[i] <= req_id_i[i];
                end
                if (w_grant[i]) begin
                    r_code[i] <= w_verdict[w_grant_port[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_fractal_sync_rf_sched.sv
// Testbench for fractal_sync_rf_sched. A small behavioural local RF (N_REGS=4,
// local index = id >> 1) answers the check ports; directed scenarios use
// hand-derived expectations and a randomized phase is scored against a
// transaction-level reference model of the scheduler.

module tb_fractal_sync_rf_sched;

    localparam int N_REQ    = 4;
    localparam int N_PORTS  = 2;
    localparam int ID_WIDTH = 4;
    localparam int N_REGS   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             rst;
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0][ID_WIDTH-1:0]   req_id;
    logic [N_REQ-1:0]                 req_ready;
    logic [N_REQ-1:0]                 rsp_valid;
    logic [N_REQ-1:0][2:0]            rsp_code;
    logic [N_REQ-1:0]                 rsp_ready;
    logic [N_PORTS-1:0][ID_WIDTH-1:0] rf_id;
    logic [N_PORTS-1:0]               rf_check;
    logic [N_PORTS-1:0]               rf_present;
    logic [N_PORTS-1:0]               rf_id_err;
    logic [N_PORTS-1:0]               rf_bypass;
    logic [N_PORTS-1:0]               rf_ignore;

    int n_cmp = 0;
    int n_err = 0;

    fractal_sync_rf_sched #(
        .N_REQ    (N_REQ),
        .N_PORTS  (N_PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_id_i     (req_id),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_code_o   (rsp_code),
        .rsp_ready_i  (rsp_ready),
        .rf_id_o      (rf_id),
        .rf_check_o   (rf_check),
        .rf_present_i (rf_present),
        .rf_id_err_i  (rf_id_err),
        .rf_bypass_i  (rf_bypass),
        .rf_ignore_i  (rf_ignore)
    );

    // ---------------- behavioural local RF ----------------
    logic [N_REGS-1:0] rf_flag;
    logic              rf_clr;

    // Same-cycle collision on one local index: lowest port bypasses, others ignore.
    always_comb begin
        rf_present = '0;
        rf_id_err  = '0;
        rf_bypass  = '0;
        rf_ignore  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (rf_check[p]) begin
                if (int'(rf_id[p][3:1]) >= N_REGS) begin
                    rf_id_err[p] = 1'b1;
                end else begin
                    logic lower;
                    logic higher;
                    lower  = 1'b0;
                    higher = 1'b0;
                    for (int q = 0; q < N_PORTS; q++) begin
                        if (q != p && rf_check[q] && rf_id[q][3:1] == rf_id[p][3:1]) begin
                            if (q < p) lower = 1'b1;
                            else       higher = 1'b1;
                        end
                    end
                    if (lower)       rf_ignore[p]  = 1'b1;
                    else if (higher) rf_bypass[p]  = 1'b1;
                    else             rf_present[p] = rf_flag[rf_id[p][2:1]];
                end
            end
        end
    end

    // A lone valid check records an absent barrier or consumes a present one.
    always @(posedge clk) begin
        if (rf_clr) begin
            rf_flag <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (rf_check[p] && !rf_id_err[p] && !rf_bypass[p] && !rf_ignore[p])
                    rf_flag[rf_id[p][2:1]] <= ~rf_flag[rf_id[p][2:1]];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rf_clr    = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        tick();
        rst    = 1'b0;
        rf_clr = 1'b0;
    endtask

    function automatic logic [2:0] verdict(input logic e, input logic ig,
                                           input logic by, input logic pr);
        if (e)  return 3'd4;
        if (ig) return 3'd3;
        if (by) return 3'd2;
        if (pr) return 3'd1;
        return 3'd0;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        rf_clr    = 1'b1;
        req_valid = '1;
        req_id    = {4'h9, 4'h7, 4'h5, 4'h3};
        rsp_ready = '0;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL reset_ready: got %b expected 1111", req_ready); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_cmp++; if (rsp_code !== 12'h000) begin n_err++; $display("FAIL reset_rsp_code: got %h expected 000", rsp_code); end
        n_cmp++; if (rf_check !== 2'b00) begin n_err++; $display("FAIL reset_rf_check: got %b expected 00", rf_check); end
        n_cmp++; if (rf_id !== 8'h00) begin n_err++; $display("FAIL reset_rf_id: got %h expected 00", rf_id); end
        tick();
        rst       = 1'b0;
        rf_clr    = 1'b0;
        req_valid = '0;
        tick();
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL reset_no_capture: got %b expected 1111", req_ready); end
        n_cmp++; if (rf_check !== 2'b00) begin n_err++; $display("FAIL reset_no_grant: got %b expected 00", rf_check); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_id    = {4'h6, 4'h4, 4'h2, 4'h0};
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL rr_accept: got %b expected 1111", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rf_check !== 2'b11) begin n_err++; $display("FAIL rr_grant1_check: got %b expected 11", rf_check); end
        n_cmp++; if (rf_id !== 8'h20) begin n_err++; $display("FAIL rr_grant1_id: got %h expected 20", rf_id); end
        tick();
        @(negedge clk);
        n_cmp++; if (rf_id !== 8'h64 || rf_check !== 2'b11) begin n_err++; $display("FAIL rr_grant2: got check %b id %h expected 11 64", rf_check, rf_id); end
        n_cmp++; if (rsp_valid !== 4'b0011) begin n_err++; $display("FAIL rr_rsp_first: got %b expected 0011", rsp_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b1111) begin n_err++; $display("FAIL rr_rsp_all: got %b expected 1111", rsp_valid); end
        n_cmp++; if (rsp_code !== 12'h000) begin n_err++; $display("FAIL rr_codes: got %h expected 000", rsp_code); end
        n_cmp++; if (rf_check !== 2'b00) begin n_err++; $display("FAIL rr_idle_ports: got %b expected 00", rf_check); end
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b1111) begin n_err++; $display("FAIL rr_drain: got valid %b ready %b expected 0000 1111", rsp_valid, req_ready); end
        // rr_ptr must be back at 0: req0 wins port0 ahead of req2/req3.
        req_id    = {4'h5, 4'h3, 4'h0, 4'h1};
        req_valid = 4'b1101;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rf_id !== 8'h31 || rf_check !== 2'b11) begin n_err++; $display("FAIL rr_wrap: got check %b id %h expected 11 31", rf_check, rf_id); end
        tick();
        @(negedge clk);
        n_cmp++; if (rf_id !== 8'h05 || rf_check !== 2'b01) begin n_err++; $display("FAIL rr_wrap_tail: got check %b id %h expected 01 05", rf_check, rf_id); end
        n_cmp++; if (rsp_code[0] !== 3'd1 || rsp_code[2] !== 3'd1) begin n_err++; $display("FAIL rr_matched: got %0d %0d expected 1 1", rsp_code[0], rsp_code[2]); end
    endtask

    task automatic test_single();
        do_reset();
        req_id[0] = 4'h2;
        req_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b expected 1", req_ready[0]); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rf_check !== 2'b01 || rf_id[0] !== 4'h2) begin n_err++; $display("FAIL single_check: got check %b id %h expected 01 2", rf_check, rf_id[0]); end
        n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_code[0] !== 3'd0) begin n_err++; $display("FAIL single_rsp: got valid %b code %0d expected 0001 0", rsp_valid, rsp_code[0]); end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b1111) begin n_err++; $display("FAIL single_done: got valid %b ready %b expected 0000 1111", rsp_valid, req_ready); end
    endtask

    task automatic test_collision();
        do_reset();
        req_id[0] = 4'h6;
        req_id[1] = 4'h6;
        req_valid = 4'b0011;
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rf_check !== 2'b11 || rf_id !== 8'h66) begin n_err++; $display("FAIL coll_grant: got check %b id %h expected 11 66", rf_check, rf_id); end
        tick();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0011) begin n_err++; $display("FAIL coll_rsp: got %b expected 0011", rsp_valid); end
        n_cmp++; if (rsp_code[0] !== 3'd2 || rsp_code[1] !== 3'd3) begin n_err++; $display("FAIL coll_codes: got %0d %0d expected 2 3", rsp_code[0], rsp_code[1]); end
        rsp_ready = 4'b0011;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_id_err();
        do_reset();
        req_id[2] = 4'hE;
        req_valid = 4'b0100;
        @(negedge clk);
        n_cmp++; if (req_ready[2] !== 1'b1) begin n_err++; $display("FAIL iderr_accept: got %b expected 1", req_ready[2]); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rf_check !== 2'b01 || rf_id[0] !== 4'hE || rsp_valid[2] !== 1'b0) begin n_err++; $display("FAIL iderr_check: got check %b id %h rsp %b expected 01 e 0", rf_check, rf_id[0], rsp_valid[2]); end
        tick();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0100 || rsp_code[2] !== 3'd4) begin n_err++; $display("FAIL iderr_rsp: got valid %b code %0d expected 0100 4", rsp_valid, rsp_code[2]); end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        req_id[1] = 4'hE;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0010 || rsp_code[1] !== 3'd4) begin n_err++; $display("FAIL bp_rsp: got valid %b code %0d expected 0010 4", rsp_valid, rsp_code[1]); end
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (rsp_valid[1] !== 1'b1 || rsp_code[1] !== 3'd4 || req_ready[1] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid %b code %0d ready %b expected 1 4 0", c, rsp_valid[1], rsp_code[1], req_ready[1]);
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin n_err++; $display("FAIL bp_reset: got valid %b ready %b expected 0 1", rsp_valid[1], req_ready[1]); end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL bp_discard%0d: got %b expected 0000", c, rsp_valid); end
        end
    endtask

    // Randomized traffic scored against a transaction-level model: each
    // requester is free / waiting / holding an answer, grants follow the
    // rotating scan, verdicts come from the RF answer on the granted port.
    task automatic test_random();
        int                        m_st [N_REQ];   // 0 free, 1 waiting, 2 answered
        logic [ID_WIDTH-1:0]       m_id [N_REQ];
        logic [2:0]                m_code [N_REQ];
        int                        m_rr;
        int                        gp [N_REQ];
        int                        used;
        int                        last;
        int                        idx;
        logic [N_REQ-1:0]          e_ready, e_valid;
        logic [N_REQ-1:0][2:0]     e_code, d_code;
        logic [N_PORTS-1:0]        e_check;
        logic [N_PORTS-1:0][ID_WIDTH-1:0] e_id;

        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            m_st[i] = 0; m_id[i] = '0; m_code[i] = '0;
        end
        m_rr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            req_id    = 16'($urandom);
            rsp_ready = 4'($urandom);
            @(negedge clk);
            used = 0;
            last = -1;
            e_check = '0;
            e_id    = '0;
            for (int i = 0; i < N_REQ; i++) begin
                gp[i]      = -1;
                e_ready[i] = (m_st[i] == 0);
                e_valid[i] = (m_st[i] == 2);
                e_code[i]  = (m_st[i] == 2) ? m_code[i] : 3'd0;
                d_code[i]  = (m_st[i] == 2) ? rsp_code[i] : 3'd0;
            end
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_rr + k) % N_REQ;
                if (m_st[idx] == 1 && used < N_PORTS) begin
                    e_check[used] = 1'b1;
                    e_id[used]    = m_id[idx];
                    gp[idx]       = used;
                    last          = idx;
                    used++;
                end
            end
            n_cmp++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, e_ready); end
            n_cmp++; if (rsp_valid !== e_valid) begin n_err++; $display("FAIL rnd_rsp_valid@%0d: got %b expected %b", cyc, rsp_valid, e_valid); end
            n_cmp++; if (d_code !== e_code) begin n_err++; $display("FAIL rnd_code@%0d: got %h expected %h", cyc, d_code, e_code); end
            n_cmp++; if (rf_check !== e_check) begin n_err++; $display("FAIL rnd_rf_check@%0d: got %b expected %b", cyc, rf_check, e_check); end
            n_cmp++; if (rf_id !== e_id) begin n_err++; $display("FAIL rnd_rf_id@%0d: got %h expected %h", cyc, rf_id, e_id); end
            if (rst) begin
                for (int i = 0; i < N_REQ; i++) begin
                    m_st[i] = 0; m_id[i] = '0; m_code[i] = '0;
                end
                m_rr = 0;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (m_st[i] == 0 && req_valid[i]) begin
                        m_st[i] = 1;
                        m_id[i] = req_id[i];
                    end else if (m_st[i] == 1 && gp[i] >= 0) begin
                        m_st[i]   = 2;
                        m_code[i] = verdict(rf_id_err[gp[i]], rf_ignore[gp[i]],
                                            rf_bypass[gp[i]], rf_present[gp[i]]);
                    end else if (m_st[i] == 2 && rsp_ready[i]) begin
                        m_st[i] = 0;
                    end
                end
                if (last >= 0) m_rr = (last + 1) % N_REQ;
            end
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
    endtask

    initial begin
        rst       = 1'b1;
        rf_clr    = 1'b1;
        req_valid = '0;
        req_id    = '0;
        rsp_ready = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_collision();
        test_id_err();
        test_backpressure_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
